// File: rtl/maddsub_pkg.sv
// maddsub_pkg: shared op encodings, FSM states and HI/LO width for the MAddSub multiplier.
package maddsub_pkg;
    localparam int HILO_W = 64;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MADDU = 3'b011;
    localparam logic [2:0] OP_MSUB  = 3'b100;
    localparam logic [2:0] OP_MSUBU = 3'b101;
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_MUL, ST_PROD, ST_SUM} state_t;
    // op[2:1] selects the accumulate class directly; 11 marks the illegal encodings
    typedef enum logic [1:0] {ACC_SET = 2'd0, ACC_ADD = 2'd1, ACC_SUB = 2'd2, ACC_NONE = 2'd3} acc_t;
    function automatic acc_t op_acc(input logic [2:0] op);
        return acc_t'(op[2:1]);
    endfunction
    function automatic logic op_signed(input logic [2:0] op);
        return ~op[0];
    endfunction
endpackage

// File: rtl/mult_pp_combine.sv
// mult_pp_combine: merges four 16x16 partial products, applies the sign and
// folds the product into HI/LO for MULT/MADD/MSUB.
module mult_pp_combine
    import maddsub_pkg::*;
(
    input  logic [31:0]       i_p_ll,
    input  logic [31:0]       i_p_lh,
    input  logic [31:0]       i_p_hl,
    input  logic [31:0]       i_p_hh,
    input  logic              i_neg,
    input  acc_t              i_acc,
    input  logic [HILO_W-1:0] i_hilo,
    output logic [HILO_W-1:0] o_result
);
    logic [32:0]       w_mid;
    logic [HILO_W-1:0] w_prod;
    logic [HILO_W-1:0] w_signed;
    always_comb begin
        w_mid    = {1'b0, i_p_lh} + {1'b0, i_p_hl};
        w_prod   = {i_p_hh, 32'd0} + {15'd0, w_mid, 16'd0} + {32'd0, i_p_ll};
        w_signed = i_neg ? -w_prod : w_prod;
        o_result = i_acc == ACC_ADD ? i_hilo + w_signed :
                   i_acc == ACC_SUB ? i_hilo - w_signed : w_signed;
    end
endmodule

// File: rtl/mult_32x32_sequencer.sv
// mult_32x32_sequencer: steps four DSP48A1 16x16 slices through a 32x32
// multiply and owns the architectural HI/LO pair.
module mult_32x32_sequencer
    import maddsub_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic [15:0] dsp_al,
    output logic [15:0] dsp_ah,
    output logic [15:0] dsp_bl,
    output logic [15:0] dsp_bh,
    output logic        dsp_cea,
    output logic        dsp_ceb,
    output logic        dsp_cem,
    output logic        dsp_cep,
    output logic        dsp_rst,
    input  logic [31:0] p_ll,
    input  logic [31:0] p_lh,
    input  logic [31:0] p_hl,
    input  logic [31:0] p_hh,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t            r_state, w_next;
    acc_t              r_acc;
    logic              r_neg, r_busy, r_done;
    logic [31:0]       r_a, r_b, r_hi, r_lo;
    logic              w_accept, w_sgn;
    logic [31:0]       w_mag_rs, w_mag_rt;
    logic [HILO_W-1:0] w_result;

    assign w_accept = r_state == ST_IDLE && req_valid;
    assign w_sgn    = op_signed(req_op);
    assign w_mag_rs = (w_sgn && req_rs[31]) ? -req_rs : req_rs;
    assign w_mag_rt = (w_sgn && req_rt[31]) ? -req_rt : req_rt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_next != ST_IDLE;
            r_done  <= w_next == ST_SUM;
        end
    end

    always_comb begin
        w_next  = r_state;
        dsp_cea = r_state == ST_LOAD;
        dsp_ceb = r_state == ST_LOAD;
        dsp_cem = r_state == ST_MUL;
        dsp_cep = r_state == ST_PROD;
        dsp_rst = flush && r_state != ST_IDLE;
        case (r_state)
            ST_IDLE: w_next = req_valid ? ST_LOAD : ST_IDLE;
            ST_LOAD: w_next = ST_MUL;
            ST_MUL:  w_next = ST_PROD;
            ST_PROD: w_next = ST_SUM;
            default: w_next = ST_IDLE;
        endcase
        if (dsp_rst) w_next = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= ACC_SET;
            r_neg <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_acc <= op_acc(req_op);
                r_neg <= w_sgn & (req_rs[31] ^ req_rt[31]);
                r_a   <= w_mag_rs;
                r_b   <= w_mag_rt;
            end
            if (wr_hi) r_hi <= wr_data;
            if (wr_lo) r_lo <= wr_data;
            // the result write is placed last so it overrides MTHI/MTLO in SUM
            if (r_state == ST_SUM && !flush && r_acc != ACC_NONE) {r_hi, r_lo} <= w_result;
        end
    end

    mult_pp_combine u_combine (
        .i_p_ll   (p_ll),
        .i_p_lh   (p_lh),
        .i_p_hl   (p_hl),
        .i_p_hh   (p_hh),
        .i_neg    (r_neg),
        .i_acc    (r_acc),
        .i_hilo   ({r_hi, r_lo}),
        .o_result (w_result)
    );

    assign req_ready = r_state == ST_IDLE;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dsp_al    = r_a[15:0];
    assign dsp_ah    = r_a[31:16];
    assign dsp_bl    = r_b[15:0];
    assign dsp_bh    = r_b[31:16];
endmodule

// File: tb/tb_mult_32x32_sequencer.sv
// tb_mult_32x32_sequencer: directed tests with a behavioural model of the
// four DSP slices (A/B -> M -> P pipeline) feeding the partial products.
module tb_mult_32x32_sequencer;
    import maddsub_pkg::*;
    logic        clock = 0, reset = 1;
    logic        req_valid = 0, req_ready, flush = 0, wr_hi = 0, wr_lo = 0;
    logic [2:0]  req_op = 0;
    logic [31:0] req_rs = 0, req_rt = 0, wr_data = 0;
    logic [15:0] dsp_al, dsp_ah, dsp_bl, dsp_bh;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst, busy, done;
    logic [31:0] p_ll = 0, p_lh = 0, p_hl = 0, p_hh = 0, hi, lo;
    logic [15:0] m_al = 0, m_ah = 0, m_bl = 0, m_bh = 0;
    logic [31:0] m_ll = 0, m_lh = 0, m_hl = 0, m_hh = 0;
    int checks = 0, errors = 0;

    mult_32x32_sequencer dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .flush(flush),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .dsp_al(dsp_al), .dsp_ah(dsp_ah), .dsp_bl(dsp_bl), .dsp_bh(dsp_bh),
        .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
        .dsp_rst(dsp_rst), .p_ll(p_ll), .p_lh(p_lh), .p_hl(p_hl), .p_hh(p_hh),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (dsp_rst) begin
            m_al <= 0; m_ah <= 0; m_bl <= 0; m_bh <= 0;
            m_ll <= 0; m_lh <= 0; m_hl <= 0; m_hh <= 0;
            p_ll <= 0; p_lh <= 0; p_hl <= 0; p_hh <= 0;
        end else begin
            if (dsp_cea) begin m_al <= dsp_al; m_ah <= dsp_ah; end
            if (dsp_ceb) begin m_bl <= dsp_bl; m_bh <= dsp_bh; end
            if (dsp_cem) begin
                m_ll <= {16'd0, m_al} * {16'd0, m_bl};
                m_lh <= {16'd0, m_al} * {16'd0, m_bh};
                m_hl <= {16'd0, m_ah} * {16'd0, m_bl};
                m_hh <= {16'd0, m_ah} * {16'd0, m_bh};
            end
            if (dsp_cep) begin p_ll <= m_ll; p_lh <= m_lh; p_hl <= m_hl; p_hh <= m_hh; end
        end
    end

    task automatic step;
        @(posedge clock); #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        req_valid = 1; req_op = op; req_rs = rs; req_rt = rt;
        step;
        req_valid = 0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 10) begin step; n++; end
    endtask

    task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
        wr_hi = h; wr_lo = l; wr_data = d;
        step;
        wr_hi = 0; wr_lo = 0;
    endtask

    task automatic test_reset;
        #12;
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
        checks++; if ({req_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b expected 100", {req_ready, busy, done}); end
        checks++; if ({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst} !== 5'b0) begin errors++; $display("FAIL reset_ce: got %b expected 00000", {dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst}); end
        checks++; if ({dsp_ah, dsp_al, dsp_bh, dsp_bl} !== 64'd0) begin errors++; $display("FAIL reset_halves: got %h expected 0", {dsp_ah, dsp_al, dsp_bh, dsp_bl}); end
        reset = 0;
        step;
    endtask

    task automatic test_mult;
        issue(OP_MULT, 32'hFFFFFFFF, 32'h00000002);
        checks++; if ({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, busy, req_ready} !== 6'b110010) begin errors++; $display("FAIL mult_c1: got %b expected 110010", {dsp_cea, dsp_ceb, dsp_cem, dsp_cep, busy, req_ready}); end
        checks++; if ({dsp_ah, dsp_al, dsp_bh, dsp_bl} !== 64'h0000_0001_0000_0002) begin errors++; $display("FAIL mult_halves: got %h expected 0000000100000002", {dsp_ah, dsp_al, dsp_bh, dsp_bl}); end
        step;
        checks++; if ({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, done} !== 5'b00100) begin errors++; $display("FAIL mult_c2: got %b expected 00100", {dsp_cea, dsp_ceb, dsp_cem, dsp_cep, done}); end
        step;
        checks++; if ({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, done} !== 5'b00010) begin errors++; $display("FAIL mult_c3: got %b expected 00010", {dsp_cea, dsp_ceb, dsp_cem, dsp_cep, done}); end
        step;
        checks++; if ({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, done} !== 5'b00001) begin errors++; $display("FAIL mult_c4: got %b expected 00001", {dsp_cea, dsp_ceb, dsp_cem, dsp_cep, done}); end
        step;
        checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFE) begin errors++; $display("FAIL mult_result: got %h expected FFFFFFFFFFFFFFFE", {hi, lo}); end
        checks++; if ({done, busy, req_ready} !== 3'b001) begin errors++; $display("FAIL mult_c5: got %b expected 001", {done, busy, req_ready}); end
    endtask

    task automatic test_multu_and_min;
        int n;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
        wait_done(n);
        checks++; if (n !== 4) begin errors++; $display("FAIL multu_latency: got %0d expected 4", n); end
        step;
        checks++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL multu_result: got %h expected 00000001FFFFFFFE", {hi, lo}); end
        issue(OP_MULT, 32'h80000000, 32'h80000000);
        wait_done(n);
        step;
        checks++; if ({hi, lo} !== 64'h40000000_00000000) begin errors++; $display("FAIL mult_min: got %h expected 4000000000000000", {hi, lo}); end
    endtask

    task automatic test_accumulate;
        int n;
        write_hilo(1, 1, 32'd0);
        write_hilo(0, 1, 32'd5);
        checks++; if ({hi, lo} !== 64'd5) begin errors++; $display("FAIL mtlo: got %h expected 5", {hi, lo}); end
        issue(OP_MADD, 32'd3, 32'd4);
        wait_done(n);
        step;
        checks++; if ({hi, lo} !== 64'd17) begin errors++; $display("FAIL madd: got %h expected 11", {hi, lo}); end
        write_hilo(1, 1, 32'd0);
        issue(OP_MSUBU, 32'd1, 32'd1);
        wait_done(n);
        step;
        checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL msubu: got %h expected FFFFFFFFFFFFFFFF", {hi, lo}); end
    endtask

    task automatic test_flush;
        logic seen;
        issue(OP_MADD, 32'd7, 32'd9);
        step;
        flush = 1;
        #1;
        checks++; if ({dsp_rst, done} !== 2'b10) begin errors++; $display("FAIL flush_rst: got %b expected 10", {dsp_rst, done}); end
        step;
        flush = 0;
        #1;
        checks++; if ({req_ready, busy, done, dsp_rst} !== 4'b1000) begin errors++; $display("FAIL flush_idle: got %b expected 1000", {req_ready, busy, done, dsp_rst}); end
        seen = 0;
        for (int i = 0; i < 4; i++) begin step; seen = seen | done; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", seen); end
        checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFF) begin errors++; $display("FAIL flush_hilo: got %h expected FFFFFFFFFFFFFFFF", {hi, lo}); end
    endtask

    task automatic test_wr_in_sum;
        int n;
        issue(OP_MULT, 32'd2, 32'd3);
        wait_done(n);
        write_hilo(0, 1, 32'hAAAA5555);
        checks++; if ({hi, lo} !== 64'd6) begin errors++; $display("FAIL wr_in_sum: got %h expected 6", {hi, lo}); end
    endtask

    task automatic test_back_to_back;
        int n;
        req_valid = 1; req_op = OP_MULTU; req_rs = 32'd5; req_rt = 32'd5;
        step;
        n = 1;
        while (!req_ready && n < 10) begin step; n++; end
        req_valid = 0;
        checks++; if (n !== 5) begin errors++; $display("FAIL held_ready_cycle: got %0d expected 5", n); end
        checks++; if ({hi, lo} !== 64'd25) begin errors++; $display("FAIL held_result: got %h expected 19", {hi, lo}); end
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_no_reaccept: got %b expected 0", busy); end
    endtask

    task automatic test_illegal;
        int n;
        issue(3'b110, 32'd3, 32'd3);
        wait_done(n);
        checks++; if ({n[3:0], done} !== 5'b01001) begin errors++; $display("FAIL illegal_done: got %0d/%b expected 4/1", n, done); end
        step;
        checks++; if ({hi, lo} !== 64'd25) begin errors++; $display("FAIL illegal_hilo: got %h expected 19", {hi, lo}); end
    endtask

    task automatic test_async_reset;
        issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
        step;
        checks++; if ({dsp_cem, busy} !== 2'b11) begin errors++; $display("FAIL pre_reset_mul: got %b expected 11", {dsp_cem, busy}); end
        #2 reset = 1;
        #1;
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL async_hilo: got %h expected 0", {hi, lo}); end
        checks++; if ({req_ready, busy, done, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst} !== 8'b10000000) begin errors++; $display("FAIL async_flags: got %b expected 10000000", {req_ready, busy, done, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rst}); end
        checks++; if ({dsp_ah, dsp_al, dsp_bh, dsp_bl} !== 64'd0) begin errors++; $display("FAIL async_halves: got %h expected 0", {dsp_ah, dsp_al, dsp_bh, dsp_bl}); end
        #2 reset = 0;
        step;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu_and_min;
        test_accumulate;
        test_flush;
        test_wr_in_sum;
        test_back_to_back;
        test_illegal;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
